// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder array: phase encodings,
// step direction codes, parameter bounds and the step classifier.
package quad_enc_pkg;

    // {A,B} phase encodings along the forward sequence 00 -> 10 -> 11 -> 01
    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_10 = 2'b10;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_01 = 2'b01;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_INC  = 2'b01,
        DIR_DEC  = 2'b10,
        DIR_ILL  = 2'b11
    } dir_e;

    localparam int N_CH_MIN     = 1;
    localparam int N_CH_MAX     = 32;
    localparam int CNT_W_MIN    = 4;
    localparam int CNT_W_MAX    = 32;
    localparam int FILT_LEN_MIN = 1;
    localparam int FILT_LEN_MAX = 15;

    function automatic dir_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
        dir_e d;
        d = DIR_NONE;
        if ((prev ^ cur) == 2'b11) begin
            d = DIR_ILL;
        end else if ((prev == ST_00 && cur == ST_10) || (prev == ST_10 && cur == ST_11) ||
                     (prev == ST_11 && cur == ST_01) || (prev == ST_01 && cur == ST_00)) begin
            d = DIR_INC;
        end else if ((prev == ST_10 && cur == ST_00) || (prev == ST_11 && cur == ST_10) ||
                     (prev == ST_01 && cur == ST_11) || (prev == ST_00 && cur == ST_01)) begin
            d = DIR_DEC;
        end
        return d;
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// One encoder channel: 2-flop synchroniser, run-length glitch filter per phase,
// x4 quadrature decoder, wrapping position counter and sticky error flag.
module quad_decoder
    import quad_enc_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enc_a_i,
    input  logic             enc_b_i,
    input  logic             clr_i,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             err_o
);

    localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

    // Bit 1 = phase A, bit 0 = phase B throughout.
    logic [1:0]       sync1_q, sync2_q, fill_q;
    logic [1:0]       filt_q, filt_d;
    logic [1:0]       fvalid_q, fvalid_d;
    logic [1:0][3:0]  run_q, run_d;
    logic [1:0]       prev_q, prev_d;
    logic             primed_q, primed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    dir_e             dir;

    // Until a phase has a valid level, filt_q acts as the candidate level and
    // the run counts how long the synchronised input has agreed with it.
    always_comb begin
        filt_d   = filt_q;
        fvalid_d = fvalid_q;
        run_d    = run_q;
        if (fill_q[1]) begin
            for (int p = 0; p < 2; p++) begin
                if (sync2_q[p] != filt_q[p]) begin
                    if (!fvalid_q[p] || run_q[p] == RUN_LAST) begin
                        filt_d[p] = sync2_q[p];
                        run_d[p]  = '0;
                    end else begin
                        run_d[p] = run_q[p] + 4'd1;
                    end
                end else if (!fvalid_q[p]) begin
                    if (run_q[p] == RUN_LAST) begin
                        fvalid_d[p] = 1'b1;
                        run_d[p]    = '0;
                    end else begin
                        run_d[p] = run_q[p] + 4'd1;
                    end
                end else begin
                    run_d[p] = '0;
                end
            end
        end
    end

    always_comb begin
        dir      = decode_step(prev_q, filt_q);
        prev_d   = prev_q;
        primed_d = primed_q;
        cnt_d    = cnt_q;
        err_d    = err_q & ~err_clr_i;
        if (!primed_q) begin
            if (&fvalid_q) begin
                prev_d   = filt_q;
                primed_d = 1'b1;
            end
        end else begin
            prev_d = filt_q;
            case (dir)
                DIR_INC:  cnt_d = cnt_q + CNT_W'(1);
                DIR_DEC:  cnt_d = cnt_q - CNT_W'(1);
                DIR_ILL:  err_d = 1'b1;
                default:  cnt_d = cnt_q;
            endcase
        end
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            fill_q   <= '0;
            filt_q   <= '0;
            fvalid_q <= '0;
            run_q    <= '0;
            prev_q   <= '0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= {enc_a_i, enc_b_i};
            sync2_q  <= sync1_q;
            fill_q   <= {fill_q[0], 1'b1};
            filt_q   <= filt_d;
            fvalid_q <= fvalid_d;
            run_q    <= run_d;
            prev_q   <= prev_d;
            primed_q <= primed_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign cnt_next_o = cnt_d;
    assign err_o      = err_q;

endmodule

// File: rtl/quad_encoder_array.sv
// Array of quadrature decoders with a shared snapshot register; SNAP captures
// every channel's next-state count and SNAP_VALID marks the new capture.
module quad_encoder_array
    import quad_enc_pkg::*;
#(
    parameter int N_CH     = 12,
    parameter int CNT_W    = 16,
    parameter int FILT_LEN = 3
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [N_CH-1:0]       ENC_A,
    input  logic [N_CH-1:0]       ENC_B,
    input  logic [N_CH-1:0]       CLR,
    input  logic                  SNAP,
    input  logic                  ERR_CLR,
    output logic [N_CH*CNT_W-1:0] COUNT,
    output logic                  SNAP_VALID,
    output logic [N_CH-1:0]       ERR
);

    if (N_CH < N_CH_MIN || N_CH > N_CH_MAX || CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX ||
        FILT_LEN < FILT_LEN_MIN || FILT_LEN > FILT_LEN_MAX) begin : g_bad_param
        $error("quad_encoder_array: parameter out of legal range");
    end

    logic [N_CH*CNT_W-1:0] cnt_next;
    logic [N_CH*CNT_W-1:0] count_q, count_d;
    logic                  snap_valid_q, snap_valid_d;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        quad_decoder #(
            .CNT_W    (CNT_W),
            .FILT_LEN (FILT_LEN)
        ) u_dec (
            .clk_i      (CLK),
            .rst_ni     (RST_N),
            .enc_a_i    (ENC_A[gi]),
            .enc_b_i    (ENC_B[gi]),
            .clr_i      (CLR[gi]),
            .err_clr_i  (ERR_CLR),
            .cnt_next_o (cnt_next[gi*CNT_W +: CNT_W]),
            .err_o      (ERR[gi])
        );
    end

    always_comb begin
        count_d      = count_q;
        snap_valid_d = SNAP;
        if (SNAP) begin
            count_d = cnt_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_q      <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign COUNT      = count_q;
    assign SNAP_VALID = snap_valid_q;

endmodule

// File: tb/tb_quad_encoder_array.sv
// Bench for quad_encoder_array: positions modelled as unbounded integers moving
// along the gray sequence, reduced modulo 2^CNT_W when compared with snapshots.
module tb_quad_encoder_array;

    localparam int N_CH     = 4;
    localparam int CNT_W    = 4;
    localparam int FILT_LEN = 3;
    localparam int LAT      = FILT_LEN + 3;

    logic                  CLK = 1'b0;
    logic                  RST_N;
    logic [N_CH-1:0]       ENC_A, ENC_B, CLR;
    logic                  SNAP, ERR_CLR;
    logic [N_CH*CNT_W-1:0] COUNT;
    logic                  SNAP_VALID;
    logic [N_CH-1:0]       ERR;

    int checks = 0;
    int errors = 0;

    // Reference model: phase index into the gray sequence and integer position.
    int               ph  [N_CH];
    int               pos [N_CH];
    logic [1:0]       gray_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [CNT_W-1:0] exp_q[$];

    quad_encoder_array #(.N_CH(N_CH), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ENC_A      (ENC_A),
        .ENC_B      (ENC_B),
        .CLR        (CLR),
        .SNAP       (SNAP),
        .ERR_CLR    (ERR_CLR),
        .COUNT      (COUNT),
        .SNAP_VALID (SNAP_VALID),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [CNT_W-1:0] exp_cnt(input int ch);
        int v;
        v = pos[ch];
        return v[CNT_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input int ch);
        return COUNT[ch*CNT_W +: CNT_W];
    endfunction

    task automatic drive_phase(input int ch);
        logic [1:0] g;
        g = gray_tab[ph[ch]];
        ENC_A[ch] = g[1];
        ENC_B[ch] = g[0];
    endtask

    task automatic step(input int ch, input int dir, input int gap);
        ph[ch]  = (ph[ch] + dir + 4) % 4;
        pos[ch] = pos[ch] + dir;
        drive_phase(ch);
        ticks(gap);
    endtask

    task automatic pulse_snap();
        SNAP = 1'b1;
        tick();
        SNAP = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ENC_A = 4'b0001; ENC_B = 4'b0001; CLR = '0;
        SNAP = 1'b1; ERR_CLR = 1'b1; RST_N = 1'b0;
        ticks(3);
        checks++; if (COUNT !== '0) begin errors++; $display("FAIL reset_count: got %0h expected 0", COUNT); end
        checks++; if (SNAP_VALID !== 1'b0) begin errors++; $display("FAIL reset_snap_valid: got %0b expected 0", SNAP_VALID); end
        checks++; if (ERR !== '0) begin errors++; $display("FAIL reset_err: got %0h expected 0", ERR); end
        SNAP = 1'b0; ERR_CLR = 1'b0; RST_N = 1'b1;
        for (int c = 0; c < N_CH; c++) begin ph[c] = 0; pos[c] = 0; end
        ph[0] = 2;
        ticks(10);
        pulse_snap();
        checks++; if (SNAP_VALID !== 1'b1) begin errors++; $display("FAIL prime_snap_valid: got %0b expected 1", SNAP_VALID); end
        for (int c = 0; c < N_CH; c++) begin
            checks++;
            if (cnt_of(c) !== exp_cnt(c)) begin errors++; $display("FAIL prime_count ch%0d: got %0h expected %0h", c, cnt_of(c), exp_cnt(c)); end
        end
        checks++; if (ERR !== '0) begin errors++; $display("FAIL prime_err: got %0h expected 0", ERR); end
        tick();
        checks++; if (SNAP_VALID !== 1'b0) begin errors++; $display("FAIL prime_snap_valid_drop: got %0b expected 0", SNAP_VALID); end
    endtask

    task automatic test_fwd_rev();
        logic [CNT_W-1:0] held;
        SNAP = 1'b1;
        step(0, 1, LAT - 1);
        checks++; if (cnt_of(0) !== exp_cnt(0) - 4'd1) begin errors++; $display("FAIL latency_early: got %0h expected %0h", cnt_of(0), exp_cnt(0) - 4'd1); end
        tick();
        checks++; if (cnt_of(0) !== exp_cnt(0)) begin errors++; $display("FAIL latency_exact: got %0h expected %0h", cnt_of(0), exp_cnt(0)); end
        SNAP = 1'b0;
        ticks(20 - LAT);
        for (int i = 0; i < 7; i++) step(0, 1, 20);
        for (int i = 0; i < 3; i++) step(0, -1, 20);
        pulse_snap();
        checks++; if (cnt_of(0) !== exp_cnt(0)) begin errors++; $display("FAIL fwd_rev_count: got %0h expected %0h", cnt_of(0), exp_cnt(0)); end
        held = exp_cnt(0);
        step(0, 1, 20);
        checks++; if (cnt_of(0) !== held) begin errors++; $display("FAIL count_hold: got %0h expected %0h", cnt_of(0), held); end
    endtask

    task automatic test_glitch();
        ENC_A[1] = 1'b1; ticks(2); ENC_A[1] = 1'b0; ticks(15);
        pulse_snap();
        checks++; if (cnt_of(1) !== exp_cnt(1)) begin errors++; $display("FAIL glitch_2cyc: got %0h expected %0h", cnt_of(1), exp_cnt(1)); end
        SNAP = 1'b1;
        ENC_A[1] = 1'b1; ticks(3); ENC_A[1] = 1'b0; ticks(3);
        checks++; if (cnt_of(1) !== exp_cnt(1) + 4'd1) begin errors++; $display("FAIL glitch_3cyc_up: got %0h expected %0h", cnt_of(1), exp_cnt(1) + 4'd1); end
        ticks(2);
        checks++; if (cnt_of(1) !== exp_cnt(1) + 4'd1) begin errors++; $display("FAIL glitch_3cyc_hold: got %0h expected %0h", cnt_of(1), exp_cnt(1) + 4'd1); end
        tick();
        checks++; if (cnt_of(1) !== exp_cnt(1)) begin errors++; $display("FAIL glitch_3cyc_down: got %0h expected %0h", cnt_of(1), exp_cnt(1)); end
        SNAP = 1'b0;
        ticks(10);
    endtask

    task automatic test_wrap();
        CLR[2] = 1'b1; tick(); CLR[2] = 1'b0; pos[2] = 0;
        for (int i = 0; i < 7; i++) step(2, 1, 10);
        pulse_snap();
        checks++; if (cnt_of(2) !== exp_cnt(2)) begin errors++; $display("FAIL wrap_preload: got %0h expected %0h", cnt_of(2), exp_cnt(2)); end
        step(2, 1, 10);
        pulse_snap();
        checks++; if (cnt_of(2) !== exp_cnt(2)) begin errors++; $display("FAIL wrap_pos_to_neg: got %0h expected %0h", cnt_of(2), exp_cnt(2)); end
        step(2, -1, 10);
        pulse_snap();
        checks++; if (cnt_of(2) !== exp_cnt(2)) begin errors++; $display("FAIL wrap_neg_to_pos: got %0h expected %0h", cnt_of(2), exp_cnt(2)); end
    endtask

    task automatic test_illegal();
        ph[3] = 2; drive_phase(3);
        ticks(12);
        pulse_snap();
        checks++; if (cnt_of(3) !== exp_cnt(3)) begin errors++; $display("FAIL illegal_count: got %0h expected %0h", cnt_of(3), exp_cnt(3)); end
        checks++; if (ERR !== 4'b1000) begin errors++; $display("FAIL illegal_err_set: got %0h expected 8", ERR); end
        ticks(10);
        checks++; if (ERR !== 4'b1000) begin errors++; $display("FAIL illegal_err_sticky: got %0h expected 8", ERR); end
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
        checks++; if (ERR !== '0) begin errors++; $display("FAIL err_clr: got %0h expected 0", ERR); end
        ph[3] = 0; drive_phase(3);
        ticks(LAT - 1);
        checks++; if (ERR !== '0) begin errors++; $display("FAIL illegal_err_early: got %0h expected 0", ERR); end
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
        checks++; if (ERR !== 4'b1000) begin errors++; $display("FAIL err_set_wins: got %0h expected 8", ERR); end
        ticks(5);
        ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
        checks++; if (ERR !== '0) begin errors++; $display("FAIL err_clr_final: got %0h expected 0", ERR); end
    endtask

    task automatic test_simultaneous();
        step(1, 1, LAT - 1);
        CLR[1] = 1'b1; SNAP = 1'b1;
        tick();
        CLR[1] = 1'b0; SNAP = 1'b0;
        pos[1] = 0;
        checks++; if (cnt_of(1) !== exp_cnt(1)) begin errors++; $display("FAIL simul_count: got %0h expected %0h", cnt_of(1), exp_cnt(1)); end
        checks++; if (SNAP_VALID !== 1'b1) begin errors++; $display("FAIL simul_snap_valid: got %0b expected 1", SNAP_VALID); end
        tick();
        checks++; if (SNAP_VALID !== 1'b0) begin errors++; $display("FAIL simul_snap_valid_drop: got %0b expected 0", SNAP_VALID); end
        ticks(10);
        step(1, 1, 12);
        pulse_snap();
        checks++; if (cnt_of(1) !== exp_cnt(1)) begin errors++; $display("FAIL simul_next_step: got %0h expected %0h", cnt_of(1), exp_cnt(1)); end
    endtask

    task automatic test_random();
        int ch, r, len;
        logic [CNT_W-1:0] e;
        for (int it = 0; it < 40; it++) begin
            ch = $urandom_range(0, N_CH - 1);
            r  = $urandom_range(0, 9);
            if (r <= 5) begin
                step(ch, (r % 2 == 0) ? 1 : -1, $urandom_range(LAT + 2, 16));
            end else if (r <= 7) begin
                len = $urandom_range(1, FILT_LEN - 1);
                if (r == 6) ENC_A[ch] = ~ENC_A[ch]; else ENC_B[ch] = ~ENC_B[ch];
                ticks(len);
                drive_phase(ch);
                ticks(LAT + 4);
            end else if (r == 8) begin
                CLR[ch] = 1'b1; tick(); CLR[ch] = 1'b0;
                pos[ch] = 0;
                ticks(2);
            end else begin
                ticks($urandom_range(1, 5));
            end
            if (it % 5 == 4) begin
                for (int c = 0; c < N_CH; c++) exp_q.push_back(exp_cnt(c));
                pulse_snap();
                checks++; if (SNAP_VALID !== 1'b1) begin errors++; $display("FAIL rand_snap_valid: got %0b expected 1", SNAP_VALID); end
                for (int c = 0; c < N_CH; c++) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (cnt_of(c) !== e) begin errors++; $display("FAIL rand_count ch%0d it%0d: got %0h expected %0h", c, it, cnt_of(c), e); end
                end
            end
        end
        checks++; if (ERR !== '0) begin errors++; $display("FAIL rand_err: got %0h expected 0", ERR); end
    endtask

    initial begin
        test_reset();
        test_fwd_rev();
        test_glitch();
        test_wrap();
        test_illegal();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_encoder_array.md
QUAD_ENCODER_ARRAY -- requirements
Module: quad_encoder_array

Interface
REQ-001 Parameter N_CH, default 12: number of quadrature encoder channels, legal range 1..32.
REQ-002 Parameter CNT_W, default 16: width of each signed position counter, legal range 4..32.
REQ-003 Parameter FILT_LEN, default 3: consecutive stable samples required to accept an input level, legal range 1..15.
REQ-004 CLK  input  1  the only clock, 16 MHz nominal; all logic on its rising edge.
REQ-005 RST_N  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
REQ-006 ENC_A  input  N_CH  encoder phase A, asynchronous, bit i = channel i.
REQ-007 ENC_B  input  N_CH  encoder phase B, asynchronous, bit i = channel i.
REQ-008 CLR  input  N_CH  per-channel counter clear, synchronous, level-sampled.
REQ-009 SNAP  input  1  snapshot request strobe.
REQ-010 ERR_CLR  input  1  clears all error flags.
REQ-011 COUNT  output  N_CH*CNT_W  snapshot counts, two's complement; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-012 SNAP_VALID  output  1  one-cycle pulse marking a newly loaded COUNT.
REQ-013 ERR  output  N_CH  sticky illegal-transition flag per channel.

Function
REQ-014 Each ENC_A/ENC_B bit SHALL pass a 2-flop synchroniser before any other use.
REQ-015 The filtered level of each phase SHALL change only after FILT_LEN consecutive synchronised samples that differ from the current filtered level; any shorter excursion is discarded and resets the run length.
REQ-016 Decoding SHALL be x4: {A,B} sequence 00->10->11->01->00 = +1 per step; the reverse sequence = -1 per step.
REQ-017 A change of both filtered phases in the same cycle SHALL leave the counter unchanged and set ERR[i].
REQ-018 A counter change SHALL appear in the internal live count exactly FILT_LEN+3 cycles after a clean, stable input edge.
REQ-019 Counters SHALL wrap modulo 2^CNT_W: max positive +1 -> most negative; most negative -1 -> max positive. No saturation, no flag.
REQ-020 CLR[i]=1 SHALL set live count i to 0 on the next edge and take priority over a same-cycle step. The decoder's previous-state register SHALL still update, so no step is lost or duplicated afterwards.
REQ-021 SNAP=1 SHALL load COUNT on the same edge with every channel's next-state live count (including any same-cycle step or clear), and drive SNAP_VALID=1 for exactly the following cycle.
REQ-022 SNAP held high SHALL reload COUNT on every cycle, with SNAP_VALID high on each following cycle.
REQ-023 COUNT SHALL hold its value between snapshots.
REQ-024 ERR[i] SHALL remain set until ERR_CLR=1. ERR_CLR=1 clears all bits, but a same-cycle new illegal transition still sets its bit (set wins).
REQ-025 After reset, the first accepted filtered sample of each channel SHALL prime its previous-state register without counting or flagging an error.

Reset
REQ-026 While RST_N=0 on a CLK edge: live counts, COUNT, ERR, SNAP_VALID, synchronisers, filter run counters and prime flags SHALL all clear to 0.
REQ-027 Reset SHALL override CLR, SNAP and ERR_CLR. Reset asserted mid-motion discards any partially filtered edge.

Structure
REQ-028 A shared package quad_enc_pkg SHALL hold the state-encoding constants (00/10/11/01), the direction codes (+1, -1, none, illegal) and the parameter legality bounds.
REQ-029 Per-channel logic (synchroniser, filter, decoder, counter) SHALL be one sub-module, quad_decoder, instantiated N_CH times by a generate loop. Snapshot, SNAP_VALID and the ERR_CLR fan-out stay in the top level.

Verification
REQ-030 Reset priming: release reset with ENC_A=ENC_B=1 on channel 0, wait 10 cycles, SNAP -> COUNT ch0 = 0, ERR=0.
REQ-031 Forward/reverse (FILT_LEN=3): 8 forward steps spaced 20 cycles, then 3 reverse -> SNAP gives ch0 = +5. First count change occurs exactly 6 cycles after the first edge.
REQ-032 Glitch rejection (FILT_LEN=3): a 2-cycle pulse on ENC_A -> count unchanged. A 3-cycle pulse -> count +1, then -1 after the pulse ends.
REQ-033 Wrap (CNT_W=4): preload to +7 by 7 steps, one more forward step -> -8; one reverse step -> +7.
REQ-034 Illegal transition plus ERR_CLR: drive 00->11 on ch3 -> count unchanged, ERR[3]=1 held. ERR_CLR in the same cycle as a new illegal transition on ch3 -> ERR[3] stays 1.
REQ-035 Simultaneous events: CLR[1]=1, a step on ch1 and SNAP=1 all in one cycle -> COUNT ch1 = 0, SNAP_VALID high on the next cycle only, and the next forward step gives +1.
